// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready and a 2-entry skid buffer.
// Optional result flags (out_zero/out_ones/out_parity) enabled by LOGIC_UNIT_FLAGS_EN.
module logic_unit_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
`ifdef LOGIC_UNIT_FLAGS_EN
   output logic             out_zero,
   output logic             out_ones,
   output logic             out_parity,
`endif
   output logic [CNT_W-1:0] op_count,
   input  logic             clr_count
);

`ifdef LOGIC_UNIT_FLAGS_EN
   localparam int EW = WIDTH + 3;
`else
   localparam int EW = WIDTH;
`endif

   logic [WIDTH-1:0] res;
   logic [EW-1:0]    ent;
   logic [EW-1:0]    main_q;
   logic [EW-1:0]    skid_q;
   logic [1:0]       occ_q;
   logic [1:0]       occ_n;
   logic             rdy_q;
   logic [CNT_W-1:0] cnt_q;
   logic             acc;
   logic             xfer;

   assign acc  = in_valid && rdy_q;
   assign xfer = (occ_q != 2'd0) && out_ready;

   // Bitwise result of the selected operation on the incoming operands
   always_comb begin
      res = '0;
      unique case (in_op)
         3'b000: res = ~in_a;
         3'b001: res = in_a & in_b;
         3'b010: res = in_a | in_b;
         3'b011: res = in_a ^ in_b;
         3'b100: res = ~(in_a & in_b);
         3'b101: res = ~(in_a | in_b);
         3'b110: res = ~(in_a ^ in_b);
         3'b111: res = in_a;
      endcase
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   assign ent = {^res, &res, (res == '0), res};
`else
   assign ent = res;
`endif

   // Next buffer occupancy from accept/transfer events
   always_comb begin
      occ_n = occ_q;
      unique case (occ_q)
         2'd0: if (acc) occ_n = 2'd1;
         2'd1: begin
            if (acc && !xfer)
               occ_n = 2'd2;
            else if (!acc && xfer)
               occ_n = 2'd0;
         end
         2'd2: if (xfer) occ_n = 2'd1;
         default: occ_n = 2'd0;
      endcase
   end

   // Occupancy, registered in_ready and main/skid result storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= 2'd0;
         rdy_q  <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         occ_q <= occ_n;
         rdy_q <= (occ_n < 2'd2);
         if (acc && ((occ_q == 2'd0) || ((occ_q == 2'd1) && xfer)))
            main_q <= ent;
         else if ((occ_q == 2'd2) && xfer)
            main_q <= skid_q;
         if (acc && (occ_q == 2'd1) && !xfer)
            skid_q <= ent;
      end
   end

   // Saturating count of consumed results; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (clr_count)
         cnt_q <= '0;
      else if (xfer && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign in_ready  = rdy_q;
   assign out_valid = (occ_q != 2'd0);
   assign out_s     = main_q[WIDTH-1:0];
   assign op_count  = cnt_q;

`ifdef LOGIC_UNIT_FLAGS_EN
   assign out_zero   = main_q[WIDTH];
   assign out_ones   = main_q[WIDTH+1];
   assign out_parity = main_q[WIDTH+2];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed steps plus random traffic
// against a queue-based reference model; a CNT_W=2 twin checks saturation.
module tb_logic_unit_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [2:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_s;
   logic [15:0] op_count;
   logic        clr_count;
   logic        in_ready2;
   logic        out_valid2;
   logic [15:0] out_s2;
   logic [1:0]  op_count2;
`ifdef LOGIC_UNIT_FLAGS_EN
   logic        out_zero, out_ones, out_parity;
   logic        out_zero2, out_ones2, out_parity2;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] q[$];
   int          cnt16;
   int          cnt2;
   logic        exp_ready;
   logic        last_acc;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
`ifdef LOGIC_UNIT_FLAGS_EN
      .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
`endif
      .op_count(op_count), .clr_count(clr_count)
   );

   logic_unit_pipe #(.WIDTH(16), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready2),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid2), .out_ready(out_ready), .out_s(out_s2),
`ifdef LOGIC_UNIT_FLAGS_EN
      .out_zero(out_zero2), .out_ones(out_ones2), .out_parity(out_parity2),
`endif
      .op_count(op_count2), .clr_count(clr_count)
   );

   function automatic logic [15:0] ref_op(
      input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      case (op)
         3'd0: r = ~a;
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = a ^ b;
         3'd4: r = ~(a & b);
         3'd5: r = ~(a | b);
         3'd6: r = ~(a ^ b);
         default: r = a;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic acc, xfer;
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("in_ready2", 32'(in_ready2), 32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_valid2", 32'(out_valid2), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("out_s", 32'(out_s), 32'(q[0]));
         chk("out_s2", 32'(out_s2), 32'(q[0]));
`ifdef LOGIC_UNIT_FLAGS_EN
         chk("out_zero", 32'(out_zero), 32'(q[0] == 16'h0));
         chk("out_ones", 32'(out_ones), 32'(q[0] == 16'hFFFF));
         chk("out_parity", 32'(out_parity), 32'(^q[0]));
`endif
      end
      chk("op_count", 32'(op_count), 32'(cnt16));
      chk("op_count2", 32'(op_count2), 32'(cnt2));
      acc  = in_valid && exp_ready;
      xfer = (q.size() != 0) && out_ready;
      @(posedge clk);
      if (xfer) begin
         void'(q.pop_front());
         if (cnt16 < 65535) cnt16++;
         if (cnt2 < 3) cnt2++;
      end
      if (clr_count) begin
         cnt16 = 0;
         cnt2  = 0;
      end
      if (acc) q.push_back(ref_op(in_op, in_a, in_b));
      exp_ready = (q.size() < 2);
      last_acc  = acc;
      @(negedge clk);
   endtask

   task automatic beat(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      step();
   endtask

   initial begin
      logic [15:0] sweep_a;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = '0;
      out_ready = 1'b0;
      clr_count = 1'b0;
      cnt16     = 0;
      cnt2      = 0;
      exp_ready = 1'b0;
      last_acc  = 1'b0;

      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_s", 32'(out_s), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      step();

      out_ready = 1'b1;
      beat(3'b000, 16'h00FF, 16'h0000);
      in_valid = 1'b0;
      step();
      step();

      sweep_a = 16'hF0F0;
      for (int i = 0; i < 8; i++)
         beat(3'(i), sweep_a, 16'hCCCC);
      in_valid = 1'b0;
      step();
      step();

      out_ready = 1'b0;
      beat(3'b111, 16'd1, 16'd0);
      beat(3'b111, 16'd2, 16'd0);
      beat(3'b111, 16'd3, 16'd0);
      beat(3'b111, 16'd3, 16'd0);
      out_ready = 1'b1;
      last_acc  = 1'b0;
      for (int i = 0; i < 8 && !last_acc; i++)
         beat(3'b111, 16'd3, 16'd0);
      chk("bp_third_accepted", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();

      beat(3'b000, 16'hFFFF, 16'h0000);
      beat(3'b111, 16'h0001, 16'h0000);
      in_valid = 1'b0;
      step();
      step();

      beat(3'b011, 16'h1234, 16'h00FF);
      in_valid  = 1'b0;
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      step();

      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clr_count = ($urandom_range(0, 31) == 0);
         in_op     = 3'($urandom_range(0, 7));
         in_a      = 16'($urandom);
         in_b      = 16'($urandom);
         step();
      end
      clr_count = 1'b0;

      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) beat(3'b001, 16'hAAAA, 16'h0F0F);
      out_ready = 1'b0;
      beat(3'b010, 16'h1111, 16'h2222);
      beat(3'b101, 16'h1111, 16'h2222);
      in_valid = 1'b0;
      chk("pre_rst_full", 32'(q.size()), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_s", 32'(out_s), 32'd0);
      chk("arst_op_count", 32'(op_count), 32'd0);
      chk("arst_op_count2", 32'(op_count2), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      q.delete();
      cnt16     = 0;
      cnt2      = 0;
      exp_ready = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 3'b110;
      in_a      = 16'h5A5A;
      in_b      = 16'h0FF0;
      step();
      beat(3'b110, 16'h5A5A, 16'h0FF0);
      in_valid = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; generalises the fixed 16-bit combinational inverter to WIDTH bits and eight selectable operations.
- Valid/ready handshake on both sides, registered result, and a 2-entry skid buffer so in_ready is a registered signal.
- Saturating completed-operation counter for debug.
- Sits between the ALU operand mux and the result writeback stage.

Parameters:
- WIDTH, 16, operand/result width in bits (>=1).
- CNT_W, 16, width of the completed-operation counter (>=1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat (registered).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; ignored by NOT and PASS.
- in_op  in  3  operation select.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_s  out  WIDTH  result.
- op_count  out  CNT_W  saturating count of results consumed downstream.
- clr_count  in  1  synchronous clear of op_count.

Behaviour:
- Op encoding: 000 NOT a; 001 a AND b; 010 a OR b; 011 a XOR b; 100 NAND; 101 NOR; 110 XNOR; 111 PASS a.
- All operations are bitwise per bit index. No carries or cross-bit terms.
- Input accept: in_valid && in_ready at a clock edge. Output transfer: out_valid && out_ready at a clock edge.
- Storage: 2-entry FIFO (main register plus skid register) holding computed results. The result is computed combinationally from in_a/in_b/in_op and written at accept.
- Latency: a beat accepted at edge N appears on out_s/out_valid after edge N (visible in cycle N+1) when the buffer was empty. No combinational path from in_* to out_*.
- Ordering: strictly in order. out_s always shows the oldest entry.
- in_ready = 1 when occupancy after the current edge is < 2. It is computed registered from next-state occupancy, so it has no combinational dependence on out_ready.
- Occupancy transitions:
  - EMPTY(0): accept -> ONE.
  - ONE(1): accept without transfer -> FULL; transfer without accept -> EMPTY; both -> ONE, with the new result replacing the old.
  - FULL(2): in_ready=0. Transfer -> ONE, with the skid entry moving to main.
  - Simultaneous accept and transfer while FULL cannot occur, because in_ready is 0.
- out_s holds its value while out_valid && !out_ready (stable-until-taken). When out_valid=0, out_s holds its last value; the bench must not check it.
- op_count:
  - Increments by 1 on each output transfer; saturates at all-ones and never wraps.
  - clr_count has priority over an increment in the same cycle and yields 0.
- Reset (asserted at any time, including mid-transfer): occupancy=0, out_valid=0, in_ready=0 while rst_n low, out_s=0, op_count=0, buffered data discarded.
  - in_ready becomes 1 at the first clock edge after rst_n deasserts.

Optional Feature:
- Macro LOGIC_UNIT_FLAGS_EN.
- When defined, adds output ports out_zero (1), out_ones (1) and out_parity (1).
  - The three flags are stored alongside each buffered result and describe the entry currently on out_s: result==0, result all-ones, XOR-reduction of the result.
  - Same timing and stability rules as out_s; all reset to 0.
- When undefined, the ports and flag storage are absent and behaviour is otherwise identical.

Test Plan:
- WIDTH=16, out_ready=1, op=000, a=16'h00FF -> out_s=16'hFF00 one cycle after accept; op_count=1.
- Sweep ops 000..111 with a=16'hF0F0, b=16'hCCCC, out_ready=1 -> out_s = 0F0F, C0C0, FCFC, 3C3C, 3F3F, 0303, C3C3, F0F0 in order; op_count=8.
- Back-pressure: out_ready=0, send 3 beats (a=1,2,3, op=111) -> first two accepted, in_ready=0 and third held. Raise out_ready -> outputs 1, 2, 3 in order with out_s stable while stalled.
- CNT_W=2: 5 transfers -> op_count 1, 2, 3, 3, 3. Assert clr_count together with a transfer -> op_count=0.
- Reset mid-operation with buffer FULL -> out_valid=0, op_count=0, out_s=0 immediately (async). in_ready=1 after the first edge post-release; a new beat then produces the correct result.
- With LOGIC_UNIT_FLAGS_EN: op=000, a=16'hFFFF -> out_s=0, out_zero=1, out_ones=0, out_parity=0. Then op=111, a=16'h0001 -> out_zero=0, out_parity=1.
